// File: rtl/cp0_pkg.sv
// cp0_pkg: shared CP0 definitions for the write-tracking pipe.
//   - CP0 address constants, encoded as {reg[4:0], sel[2:0]}
//   - WATCH_ADDR: dedicated watched registers, entry k at WATCH_ADDR[k]
//   - slot_t: one in-flight write {valid, addr, data}
package cp0_pkg;

    localparam int CP0_DATA_W = 32;
    localparam int CP0_ADDR_W = 8;

    localparam logic [CP0_ADDR_W-1:0] COUNT   = {5'd9,  3'd0};
    localparam logic [CP0_ADDR_W-1:0] STATUS  = {5'd12, 3'd0};
    localparam logic [CP0_ADDR_W-1:0] CAUSE   = {5'd13, 3'd0};
    localparam logic [CP0_ADDR_W-1:0] EPC     = {5'd14, 3'd0};
    localparam logic [CP0_ADDR_W-1:0] CONFIG0 = {5'd16, 3'd0};

    localparam int WATCH_MAX = 5;

    // Packed so that WATCH_ADDR[k] selects entry k (k = 0 is COUNT).
    localparam logic [WATCH_MAX-1:0][CP0_ADDR_W-1:0] WATCH_ADDR =
        {CONFIG0, EPC, CAUSE, STATUS, COUNT};

    typedef struct packed {
        logic                  valid;
        logic [CP0_ADDR_W-1:0] addr;
        logic [CP0_DATA_W-1:0] data;
    } slot_t;

endpackage

// File: rtl/cp0_write_pipe_if.sv
// cp0_write_pipe_if: execute-side / CP0-file-side signal bundle of the
// CP0 write pipe.
//   slave  : the write pipe (receives issue/read requests, drives
//            forwarded data and commit)
//   master : the surrounding core / testbench
interface cp0_write_pipe_if
    import cp0_pkg::*;
#(
    parameter int DATA_W    = CP0_DATA_W,
    parameter int ADDR_W    = CP0_ADDR_W,
    parameter int DEPTH     = 2,
    parameter int NUM_WATCH = WATCH_MAX
) ();

    logic                          stall_i;
    logic                          flush_i;
    logic                          wr_valid_i;
    logic [ADDR_W-1:0]             wr_addr_i;
    logic [DATA_W-1:0]             wr_data_i;
    logic [ADDR_W-1:0]             rd_addr_i;
    logic [DATA_W-1:0]             cp0_rd_data_i;
    logic [DATA_W-1:0]             rd_data_o;
    logic [NUM_WATCH*DATA_W-1:0]   watch_i;
    logic [NUM_WATCH*DATA_W-1:0]   watch_o;
    logic                          commit_valid_o;
    logic [ADDR_W-1:0]             commit_addr_o;
    logic [DATA_W-1:0]             commit_data_o;
    logic                          irq_hold_o;
    logic [$clog2(DEPTH+1)-1:0]    pending_cnt_o;

    modport slave (
        input  stall_i, flush_i, wr_valid_i, wr_addr_i, wr_data_i,
               rd_addr_i, cp0_rd_data_i, watch_i,
        output rd_data_o, watch_o, commit_valid_o, commit_addr_o,
               commit_data_o, irq_hold_o, pending_cnt_o
    );

    modport master (
        output stall_i, flush_i, wr_valid_i, wr_addr_i, wr_data_i,
               rd_addr_i, cp0_rd_data_i, watch_i,
        input  rd_data_o, watch_o, commit_valid_o, commit_addr_o,
               commit_data_o, irq_hold_o, pending_cnt_o
    );

endinterface

// File: rtl/cp0_fwd_mux.sv
// cp0_fwd_mux: priority address match over the in-flight slot array.
//   slots : slot array, index 0 youngest
//   addr  : address to look up
//   hit   : some valid slot matches addr
//   data  : data of the youngest matching slot (0 when no hit)
module cp0_fwd_mux
    import cp0_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  slot_t [DEPTH-1:0]      slots,
    input  logic [CP0_ADDR_W-1:0]  addr,
    output logic                   hit,
    output logic [CP0_DATA_W-1:0]  data
);

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (slots[i].valid && (slots[i].addr == addr)) begin
                hit  = 1'b1;
                data = slots[i].data;
            end
        end
    end

endmodule

// File: rtl/cp0_write_pipe.sv
// cp0_write_pipe: DEPTH-slot in-flight tracker for CP0 writes (mtc0).
// Writes enter slot 0, shift toward slot DEPTH-1 on every advancing edge,
// and are committed to the CP0 file from the oldest slot. In-flight values
// are forwarded to the general read port and to the watched-register bus.
//   clk, rst_n       : clock, asynchronous active-low reset
//   bus.stall_i      : hold all slots, ignore incoming write
//   bus.flush_i      : invalidate all slots; oldest still commits this cycle
//   bus.wr_*         : write issue
//   bus.rd_addr_i / cp0_rd_data_i / rd_data_o : forwarded general read
//   bus.watch_i / watch_o : forwarded watched registers (WATCH_ADDR order)
//   bus.commit_*     : CP0 file write port
//   bus.irq_hold_o   : STATUS or CAUSE write still in flight
//   bus.pending_cnt_o: number of valid slots
// Slot widths follow cp0_pkg (CP0_DATA_W / CP0_ADDR_W); DATA_W and ADDR_W
// are expected to match them.
module cp0_write_pipe
    import cp0_pkg::*;
#(
    parameter int DATA_W    = CP0_DATA_W,
    parameter int ADDR_W    = CP0_ADDR_W,
    parameter int DEPTH     = 2,
    parameter int NUM_WATCH = WATCH_MAX
) (
    input  logic             clk,
    input  logic             rst_n,
    cp0_write_pipe_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    slot_t [DEPTH-1:0]  slots;
    logic [ADDR_W-1:0]  rd_addr;
    logic               rd_hit;
    logic [DATA_W-1:0]  rd_fwd;
    logic [CNT_W-1:0]   pending;
    logic               irq_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots <= '0;
        end else if (bus.flush_i) begin
            slots <= '0;
        end else if (!bus.stall_i) begin
            slots[0] <= {bus.wr_valid_i, bus.wr_addr_i, bus.wr_data_i};
            for (int i = 1; i < DEPTH; i++) begin
                slots[i] <= slots[i-1];
            end
        end
    end

    // A flush still lets the oldest write out: it predates the faulting
    // instruction, even when the flush arrives during a stall.
    assign bus.commit_valid_o = slots[DEPTH-1].valid & (~bus.stall_i | bus.flush_i);
    assign bus.commit_addr_o  = slots[DEPTH-1].addr;
    assign bus.commit_data_o  = slots[DEPTH-1].data;

    assign rd_addr = bus.rd_addr_i;

    cp0_fwd_mux #(.DEPTH(DEPTH)) u_rd_fwd (
        .slots (slots),
        .addr  (rd_addr),
        .hit   (rd_hit),
        .data  (rd_fwd)
    );

    assign bus.rd_data_o = rd_hit ? rd_fwd : bus.cp0_rd_data_i;

    for (genvar k = 0; k < NUM_WATCH; k++) begin : g_watch
        logic              hit;
        logic [DATA_W-1:0] fwd;

        cp0_fwd_mux #(.DEPTH(DEPTH)) u_watch_fwd (
            .slots (slots),
            .addr  (WATCH_ADDR[k]),
            .hit   (hit),
            .data  (fwd)
        );

        assign bus.watch_o[k*DATA_W +: DATA_W] = hit ? fwd : bus.watch_i[k*DATA_W +: DATA_W];
    end

    always_comb begin
        pending  = '0;
        irq_hold = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            pending = pending + CNT_W'(slots[i].valid);
            if (slots[i].valid && ((slots[i].addr == STATUS) || (slots[i].addr == CAUSE))) begin
                irq_hold = 1'b1;
            end
        end
    end

    assign bus.pending_cnt_o = pending;
    assign bus.irq_hold_o    = irq_hold;

endmodule

// File: tb/tb_cp0_write_pipe.sv
module tb_cp0_write_pipe;
    import cp0_pkg::*;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int DEPTH = 2;
    localparam int NW = 5;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    logic [NW*DW-1:0] watch_ref;
    logic [NW*DW-1:0] watch_exp;

    cp0_write_pipe_if #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .NUM_WATCH(NW)) bus ();

    cp0_write_pipe #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .NUM_WATCH(NW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.stall_i    = 1'b0;
        bus.flush_i    = 1'b0;
        bus.wr_valid_i = 1'b0;
        bus.wr_addr_i  = '0;
        bus.wr_data_i  = '0;
    endtask

    task automatic issue(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.wr_valid_i = 1'b1;
        bus.wr_addr_i  = a;
        bus.wr_data_i  = d;
    endtask

    task automatic test_reset;
        #2;
        n_cmp++; if (bus.commit_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_commit_valid got %0b want 0", bus.commit_valid_o); end
        n_cmp++; if (bus.commit_addr_o !== 8'h00) begin n_err++; $display("FAIL reset_commit_addr got %h want 00", bus.commit_addr_o); end
        n_cmp++; if (bus.commit_data_o !== 32'h0) begin n_err++; $display("FAIL reset_commit_data got %h want 0", bus.commit_data_o); end
        n_cmp++; if (bus.irq_hold_o !== 1'b0) begin n_err++; $display("FAIL reset_irq_hold got %0b want 0", bus.irq_hold_o); end
        n_cmp++; if (bus.pending_cnt_o !== 2'd0) begin n_err++; $display("FAIL reset_pending got %0d want 0", bus.pending_cnt_o); end
        n_cmp++; if (bus.rd_data_o !== 32'h1234_5678) begin n_err++; $display("FAIL reset_rd_data got %h want 12345678", bus.rd_data_o); end
        n_cmp++; if (bus.watch_o !== watch_ref) begin n_err++; $display("FAIL reset_watch got %h want %h", bus.watch_o, watch_ref); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_write;
        issue(STATUS, 32'h0000_FF01);
        tick();
        idle();
        bus.rd_addr_i     = STATUS;
        bus.cp0_rd_data_i = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if (bus.rd_data_o !== 32'h0000_FF01) begin n_err++; $display("FAIL single_fwd_c1 got %h want 0000ff01", bus.rd_data_o); end
        n_cmp++; if (bus.irq_hold_o !== 1'b1) begin n_err++; $display("FAIL single_irq_c1 got %0b want 1", bus.irq_hold_o); end
        n_cmp++; if (bus.commit_valid_o !== 1'b0) begin n_err++; $display("FAIL single_commit_c1 got %0b want 0", bus.commit_valid_o); end
        n_cmp++; if (bus.pending_cnt_o !== 2'd1) begin n_err++; $display("FAIL single_pending_c1 got %0d want 1", bus.pending_cnt_o); end
        tick();
        n_cmp++; if (bus.rd_data_o !== 32'h0000_FF01) begin n_err++; $display("FAIL single_fwd_c2 got %h want 0000ff01", bus.rd_data_o); end
        n_cmp++; if (bus.irq_hold_o !== 1'b1) begin n_err++; $display("FAIL single_irq_c2 got %0b want 1", bus.irq_hold_o); end
        n_cmp++; if (bus.commit_valid_o !== 1'b1) begin n_err++; $display("FAIL single_commit_c2 got %0b want 1", bus.commit_valid_o); end
        n_cmp++; if (bus.commit_addr_o !== STATUS) begin n_err++; $display("FAIL single_commit_addr got %h want 60", bus.commit_addr_o); end
        n_cmp++; if (bus.commit_data_o !== 32'h0000_FF01) begin n_err++; $display("FAIL single_commit_data got %h want 0000ff01", bus.commit_data_o); end
        tick();
        n_cmp++; if (bus.rd_data_o !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL single_fwd_after got %h want deadbeef", bus.rd_data_o); end
        n_cmp++; if (bus.irq_hold_o !== 1'b0) begin n_err++; $display("FAIL single_irq_after got %0b want 0", bus.irq_hold_o); end
        n_cmp++; if (bus.commit_valid_o !== 1'b0) begin n_err++; $display("FAIL single_commit_after got %0b want 0", bus.commit_valid_o); end
        n_cmp++; if (bus.pending_cnt_o !== 2'd0) begin n_err++; $display("FAIL single_pending_after got %0d want 0", bus.pending_cnt_o); end
    endtask

    task automatic test_back_to_back;
        issue(EPC, 32'h0000_0100);
        tick();
        issue(EPC, 32'h0000_0200);
        tick();
        idle();
        #1;
        watch_exp = watch_ref;
        watch_exp[3*DW +: DW] = 32'h0000_0200;
        n_cmp++; if (bus.watch_o !== watch_exp) begin n_err++; $display("FAIL b2b_watch_both got %h want %h", bus.watch_o, watch_exp); end
        n_cmp++; if (bus.pending_cnt_o !== 2'd2) begin n_err++; $display("FAIL b2b_pending got %0d want 2", bus.pending_cnt_o); end
        n_cmp++; if (bus.irq_hold_o !== 1'b0) begin n_err++; $display("FAIL b2b_irq got %0b want 0", bus.irq_hold_o); end
        n_cmp++; if ({bus.commit_valid_o, bus.commit_addr_o, bus.commit_data_o} !== {1'b1, EPC, 32'h0000_0100})
            begin n_err++; $display("FAIL b2b_commit_first got %0b/%h/%h want 1/70/00000100", bus.commit_valid_o, bus.commit_addr_o, bus.commit_data_o); end
        tick();
        n_cmp++; if ({bus.commit_valid_o, bus.commit_addr_o, bus.commit_data_o} !== {1'b1, EPC, 32'h0000_0200})
            begin n_err++; $display("FAIL b2b_commit_second got %0b/%h/%h want 1/70/00000200", bus.commit_valid_o, bus.commit_addr_o, bus.commit_data_o); end
        n_cmp++; if (bus.watch_o !== watch_exp) begin n_err++; $display("FAIL b2b_watch_one got %h want %h", bus.watch_o, watch_exp); end
        tick();
        n_cmp++; if (bus.watch_o !== watch_ref) begin n_err++; $display("FAIL b2b_watch_drained got %h want %h", bus.watch_o, watch_ref); end
        n_cmp++; if (bus.commit_valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_commit_drained got %0b want 0", bus.commit_valid_o); end
    endtask

    task automatic test_stall;
        issue(COUNT, 32'h0000_0055);
        tick();
        idle();
        tick();
        // write now sits in the oldest slot; stall with a competing write
        bus.stall_i = 1'b1;
        issue(STATUS, 32'h0000_0AAA);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (bus.commit_valid_o !== 1'b0) begin n_err++; $display("FAIL stall_commit_c%0d got %0b want 0", c, bus.commit_valid_o); end
            n_cmp++; if (bus.pending_cnt_o !== 2'd1) begin n_err++; $display("FAIL stall_pending_c%0d got %0d want 1", c, bus.pending_cnt_o); end
            tick();
        end
        idle();
        #1;
        n_cmp++; if ({bus.commit_valid_o, bus.commit_addr_o, bus.commit_data_o} !== {1'b1, COUNT, 32'h0000_0055})
            begin n_err++; $display("FAIL stall_commit_release got %0b/%h/%h want 1/48/00000055", bus.commit_valid_o, bus.commit_addr_o, bus.commit_data_o); end
        n_cmp++; if (bus.irq_hold_o !== 1'b0) begin n_err++; $display("FAIL stall_ignored_write_irq got %0b want 0", bus.irq_hold_o); end
        tick();
        n_cmp++; if (bus.pending_cnt_o !== 2'd0) begin n_err++; $display("FAIL stall_pending_after got %0d want 0", bus.pending_cnt_o); end
    endtask

    task automatic test_flush;
        issue(CAUSE, 32'h0000_0024);
        tick();
        issue(EPC, 32'h0000_0080);
        tick();
        bus.stall_i = 1'b1;
        bus.flush_i = 1'b1;
        issue(STATUS, 32'h0000_0001);
        #1;
        n_cmp++; if ({bus.commit_valid_o, bus.commit_addr_o, bus.commit_data_o} !== {1'b1, CAUSE, 32'h0000_0024})
            begin n_err++; $display("FAIL flush_commit got %0b/%h/%h want 1/68/00000024", bus.commit_valid_o, bus.commit_addr_o, bus.commit_data_o); end
        n_cmp++; if (bus.pending_cnt_o !== 2'd2) begin n_err++; $display("FAIL flush_pending_before got %0d want 2", bus.pending_cnt_o); end
        n_cmp++; if (bus.irq_hold_o !== 1'b1) begin n_err++; $display("FAIL flush_irq_before got %0b want 1", bus.irq_hold_o); end
        tick();
        idle();
        #1;
        n_cmp++; if (bus.pending_cnt_o !== 2'd0) begin n_err++; $display("FAIL flush_pending_after got %0d want 0", bus.pending_cnt_o); end
        n_cmp++; if (bus.irq_hold_o !== 1'b0) begin n_err++; $display("FAIL flush_irq_after got %0b want 0", bus.irq_hold_o); end
        n_cmp++; if (bus.watch_o !== watch_ref) begin n_err++; $display("FAIL flush_watch_after got %h want %h", bus.watch_o, watch_ref); end
        tick();
        n_cmp++; if (bus.commit_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_no_late_commit got %0b want 0", bus.commit_valid_o); end
    endtask

    task automatic test_reset_midflight;
        issue(EPC, 32'h0000_0300);
        tick();
        issue(CAUSE, 32'h0000_0400);
        tick();
        idle();
        bus.rd_addr_i     = EPC;
        bus.cp0_rd_data_i = 32'hCAFE_0001;
        #1;
        n_cmp++; if (bus.commit_valid_o !== 1'b1) begin n_err++; $display("FAIL rstmid_commit_before got %0b want 1", bus.commit_valid_o); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.commit_valid_o !== 1'b0) begin n_err++; $display("FAIL rstmid_commit_async got %0b want 0", bus.commit_valid_o); end
        n_cmp++; if (bus.rd_data_o !== 32'hCAFE_0001) begin n_err++; $display("FAIL rstmid_rd_data got %h want cafe0001", bus.rd_data_o); end
        n_cmp++; if (bus.pending_cnt_o !== 2'd0) begin n_err++; $display("FAIL rstmid_pending got %0d want 0", bus.pending_cnt_o); end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++; if (bus.commit_valid_o !== 1'b0) begin n_err++; $display("FAIL rstmid_no_commit_c%0d got %0b want 0", c, bus.commit_valid_o); end
        end
    endtask

    task automatic test_no_match;
        bus.rd_addr_i     = CONFIG0;
        bus.cp0_rd_data_i = 32'h8000_0483;
        #1;
        n_cmp++; if (bus.rd_data_o !== 32'h8000_0483) begin n_err++; $display("FAIL nomatch_rd got %h want 80000483", bus.rd_data_o); end
        n_cmp++; if (bus.watch_o !== watch_ref) begin n_err++; $display("FAIL nomatch_watch got %h want %h", bus.watch_o, watch_ref); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle();
        for (int k = 0; k < NW; k++) watch_ref[k*DW +: DW] = 32'hA000_0000 | 32'(k);
        bus.watch_i       = watch_ref;
        bus.rd_addr_i     = STATUS;
        bus.cp0_rd_data_i = 32'h1234_5678;

        test_reset();
        test_single_write();
        test_back_to_back();
        test_stall();
        test_flush();
        test_reset_midflight();
        test_no_match();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cp0_write_pipe.md
# cp0_write_pipe

Parametrised CP0 write-tracking and forwarding unit, between the execute stage and the CP0 register file. Every CP0 write (mtc0) enters a DEPTH-slot in-flight pipeline, is forwarded to readers while in flight, and is committed to the CP0 file from the oldest slot. It provides exception flush, stall hold and a pending-write indication for interrupt masking. It generalises the fixed two-source MEM/WB bypass to arbitrary depth and to a configurable set of dedicated watched registers.

## Interface
Parameters:
- DATA_W, 32, CP0 data width
- ADDR_W, 8, CP0 address width ({reg[4:0], sel[2:0]})
- DEPTH, 2, in-flight slots between issue and commit (≥1)
- NUM_WATCH, 5, dedicated watched registers (addresses from package list)

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall_i  in  1  hold all slots
- flush_i  in  1  exception flush; kills uncommitted younger writes
- wr_valid_i  in  1  CP0 write issued this cycle
- wr_addr_i  in  ADDR_W  write address
- wr_data_i  in  DATA_W  write data
- rd_addr_i  in  ADDR_W  general read address (mfc0)
- cp0_rd_data_i  in  DATA_W  CP0 file data at rd_addr_i
- rd_data_o  out  DATA_W  forwarded read data
- watch_i  in  NUM_WATCH*DATA_W  CP0 file values of watched registers, entry k at [k*DATA_W +: DATA_W]
- watch_o  out  NUM_WATCH*DATA_W  forwarded watched values
- commit_valid_o  out  1  CP0 file write enable
- commit_addr_o  out  ADDR_W  CP0 file write address
- commit_data_o  out  DATA_W  CP0 file write data
- irq_hold_o  out  1  a valid slot targets STATUS or CAUSE
- pending_cnt_o  out  $clog2(DEPTH+1)  number of valid slots

## Operation
- Slot 0 is youngest; slot DEPTH-1 is oldest and drives commit_*_o.
- Advance edge (!stall_i, !flush_i): slot[i] ← slot[i-1]. Slot 0 ← {wr_valid_i, wr_addr_i, wr_data_i}. The oldest slot leaves, committed this cycle.
- stall_i & !flush_i: all slots hold, and the incoming write is ignored (upstream also holds it).
- flush_i, regardless of stall_i: all slots invalidated at the edge and the incoming write is dropped. The oldest slot still commits in the flush cycle because it belongs to an instruction older than the faulting one.
- Commit: commit_valid_o = slot[DEPTH-1].valid & (!stall_i | flush_i). commit_addr_o and commit_data_o carry the slot's contents.
- Forwarding, rd_data_o: the youngest valid slot whose addr equals rd_addr_i wins. If no slot matches, cp0_rd_data_i. The current wr_* input is not forwarded.
- Watch entry k: same priority search against WATCH_ADDR[k], falling back to watch_i entry k.
- irq_hold_o: OR over valid slots of (addr == STATUS | addr == CAUSE).
- pending_cnt_o: popcount of slot valid bits.

## Timing
- Reset (rst_n low, asynchronous): all slots invalid, addr/data 0. Outputs then read: commit_valid_o 0, commit_addr_o 0, commit_data_o 0, irq_hold_o 0, pending_cnt_o 0, rd_data_o = cp0_rd_data_i, watch_o = watch_i.
- Issue-to-commit latency: DEPTH advancing cycles. A write issued at edge n commits in the cycle following edge n+DEPTH-1, plus stalled cycles.
- Forwarding, commit, irq_hold_o and pending_cnt_o are combinational from slot state: zero latency. Forwarding from the current wr_* input has one cycle of latency.
- Two same-address writes in flight: the younger value is forwarded, and both commit in order.
- Reset mid-flight discards all uncommitted writes, and nothing commits.
- DEPTH=1: the single slot is both youngest and commit slot.

## Structure
- Package cp0_pkg: CP0 address constants (COUNT, STATUS, CAUSE, EPC, CONFIG0), WATCH_ADDR list of NUM_WATCH addresses, and the slot struct/typedef {valid, addr, data}.
- Sub-module cp0_fwd_mux: parametrised priority match over the slot array for one address, returning {hit, data}. One instance for the read port and NUM_WATCH instances for the watch entries.

## Test plan
- Reset, then write STATUS=0x0000_FF01 with DEPTH=2: rd_addr_i=STATUS gives 0x0000_FF01 for 2 cycles. commit_valid_o pulses on the second cycle with addr STATUS and data 0x0000_FF01. irq_hold_o is high for both cycles.
- Back-to-back writes EPC=0x100 then EPC=0x200: watch_o EPC entry is 0x200 while both are in flight. Commits occur in order, 0x100 then 0x200.
- Write in flight with stall_i held 3 cycles: slots and pending_cnt_o hold, commit_valid_o is 0. Commit occurs on the first cycle after stall_i falls.
- Slots full (CAUSE=0x24 oldest, EPC=0x80 younger) and flush_i with stall_i both asserted: CAUSE commits that cycle. The EPC write and the new wr_* write are dropped, and pending_cnt_o is 0 next cycle.
- rst_n asserted with 2 writes in flight: commit_valid_o goes 0 immediately and rd_data_o = cp0_rd_data_i. Nothing commits after release.
- No matching slot, rd_addr_i=CONFIG0 with cp0_rd_data_i=0x8000_0483: rd_data_o=0x8000_0483, and watch_o equals watch_i.
